// File: rtl/spi_cmd_master.sv
// SPI mode-0 command initiator: serialises {cmd, addr, data} register requests
// as 32-bit frames; reads add a dummy frame that clocks the response back on MISO.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [31:0]   DUMMY_FRAME = 32'hFF00_0000;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state;
  logic [31:0]   frame;
  logic [31:0]   capture;
  logic [31:0]   next_frame;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bit_cnt;
  logic          is_read;
  logic          phase;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    next_frame = {(req_write ? 8'h00 : 8'h01), req_addr, (req_write ? req_wdata : 16'h0000)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      capture   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      phase     <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            frame    <= next_frame;
            spi_mosi <= next_frame[31];
            is_read  <= !req_write;
            phase    <= 1'b0;
            spi_cs_n <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            capture  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_sclk <= !spi_sclk;
            if (!spi_sclk) begin
              capture <= {capture[30:0], spi_miso};
            end else if (bit_cnt == 5'd31) begin
              state    <= GAP;
              spi_cs_n <= 1'b1;
              spi_sclk <= 1'b0;
              spi_mosi <= 1'b0;
              bit_cnt  <= '0;
              gap_cnt  <= '0;
            end else begin
              // rotate so the next bit to send always sits at frame[30]
              frame    <= {frame[30:0], frame[31]};
              spi_mosi <= frame[30];
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (is_read && !phase) begin
              phase    <= 1'b1;
              frame    <= DUMMY_FRAME;
              spi_mosi <= 1'b1;
              spi_cs_n <= 1'b0;
              div_cnt  <= '0;
              capture  <= '0;
              state    <= SHIFT;
            end else begin
              if (is_read) rsp_data <= capture;
              rsp_valid <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: cycle-accurate pin model derived from frame timing
// arithmetic, a register-block responder on the SPI pins, directed and random requests.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid, busy, spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [31:0] rsp_data;

  // CLK_DIV=2, CS_GAP=1 DUT
  logic        req_valid_b = 1'b0, req_ready_b, req_write_b = 1'b0;
  logic [7:0]  req_addr_b = '0;
  logic [15:0] req_wdata_b = '0;
  logic        rsp_valid_b, busy_b, spi_sclk_b, spi_cs_n_b, spi_mosi_b;
  logic        spi_miso_b = 1'b0;
  logic [31:0] rsp_data_b;

  spi_cmd_master u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_cmd_master #(.CLK_DIV(2), .CS_GAP(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
    .spi_sclk(spi_sclk_b), .spi_cs_n(spi_cs_n_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic cs_n;
    logic sclk;
    logic mosi;
    logic busy;
    logic rsp_valid;
  } pins_t;

  // Expected pins for cycle c of a transaction whose first SHIFT cycle is start.
  function automatic pins_t model_pins(input int c, input int start, input int nfr,
                                       input logic [31:0] w0, input bit act,
                                       input int cd, input int gap);
    pins_t p;
    int f, rel, fi, o;
    logic [31:0] w;
    p = 5'b10000;
    if (act && c >= start) begin
      f   = 64 * cd + gap;
      rel = c - start;
      fi  = rel / f;
      o   = rel % f;
      w   = (fi == 0) ? w0 : 32'hFF00_0000;
      if (fi < nfr) begin
        p.busy = 1'b1;
        if (o < 64 * cd) begin
          p.cs_n = 1'b0;
          p.sclk = ((o / cd) % 2) == 1;
          p.mosi = w[31 - o / (2 * cd)];
        end
      end else if (rel == nfr * f) begin
        p.rsp_valid = 1'b1;
      end
    end
    return p;
  endfunction

  // responder model of the register block on the default DUT's pins
  logic [31:0] regmem [256];
  typedef struct {
    logic [31:0] word;
    int rises;
    int low;
    int gap;
  } frame_t;
  frame_t frq[$];

  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [31:0] rx = '0, mword = '0, pend = '0;
  bit          pend_v = 1'b0;
  int          rises = 0, falls = 0, lowc = 0, hic = 0, gapb = 0;

  always @(negedge clk) begin
    if (prev_cs && !spi_cs_n) begin
      gapb = hic; rx = '0; rises = 0; falls = 0; lowc = 0;
      mword = pend_v ? pend : $urandom;
      pend_v = 1'b0;
      spi_miso = mword[31];
    end
    if (!spi_cs_n) begin
      lowc++;
      if (spi_sclk && !prev_sclk) begin
        rx = {rx[30:0], spi_mosi};
        rises++;
      end
      if (!spi_sclk && prev_sclk) begin
        falls++;
        if (falls < 32) spi_miso = mword[31 - falls];
      end
    end else begin
      if (!prev_cs) begin
        frq.push_back('{rx, rises, lowc, gapb});
        if (rises == 32) begin
          if (rx[31:24] == 8'h00) regmem[rx[23:16]] = {16'h0000, rx[15:0]};
          else if (rx[31:24] == 8'h01) begin
            pend = regmem[rx[23:16]];
            pend_v = 1'b1;
          end
        end
        hic = 0;
      end
      hic++;
    end
    prev_cs = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  // second DUT's responder returns a fixed word in every frame
  logic [31:0] k2 = 32'h5A3C_96E1;
  logic        prev_cs_b = 1'b1, prev_sclk_b = 1'b0;
  int          falls_b = 0;
  always @(negedge clk) begin
    if (!spi_cs_n_b) begin
      if (prev_cs_b) begin
        falls_b = 0;
        spi_miso_b = k2[31];
      end else if (!spi_sclk_b && prev_sclk_b) begin
        falls_b++;
        if (falls_b < 32) spi_miso_b = k2[31 - falls_b];
      end
    end
    prev_cs_b = spi_cs_n_b;
    prev_sclk_b = spi_sclk_b;
  end

  // per-cycle comparison, default DUT
  bit          m_act = 1'b0, m_rd = 1'b0;
  int          m_start = 0, m_nfr = 1;
  logic [31:0] m_w0 = '0, m_rdval = '0, m_rsp = '0;
  pins_t       e_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_rsp = '0;
    end
    e_a = model_pins(cyc, m_start, m_nfr, m_w0, m_act, 4, 2);
    if (e_a.rsp_valid && m_rd) m_rsp = m_rdval;
    check("pins", {spi_cs_n, spi_sclk, spi_mosi, busy, req_ready, rsp_valid},
          {e_a.cs_n, e_a.sclk, e_a.mosi, e_a.busy, !e_a.busy, e_a.rsp_valid});
    check("rsp_data", rsp_data, m_rsp);
    if (rst_n && req_valid && !e_a.busy) begin
      m_act   = 1'b1;
      m_start = cyc + 1;
      m_rd    = !req_write;
      m_nfr   = req_write ? 1 : 2;
      m_w0    = {(req_write ? 8'h00 : 8'h01), req_addr, (req_write ? req_wdata : 16'h0000)};
      m_rdval = regmem[req_addr];
    end
  end

  // per-cycle comparison, CLK_DIV=2 / CS_GAP=1 DUT
  bit          b_act = 1'b0, b_rd = 1'b0;
  int          b_start = 0, b_nfr = 1;
  logic [31:0] b_w0 = '0, b_rsp = '0;
  pins_t       e_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_act = 1'b0;
      b_rsp = '0;
    end
    e_b = model_pins(cyc, b_start, b_nfr, b_w0, b_act, 2, 1);
    if (e_b.rsp_valid && b_rd) b_rsp = k2;
    check("pins_b", {spi_cs_n_b, spi_sclk_b, spi_mosi_b, busy_b, req_ready_b, rsp_valid_b},
          {e_b.cs_n, e_b.sclk, e_b.mosi, e_b.busy, !e_b.busy, e_b.rsp_valid});
    check("rsp_data_b", rsp_data_b, b_rsp);
    if (rst_n && req_valid_b && !e_b.busy) begin
      b_act   = 1'b1;
      b_start = cyc + 1;
      b_rd    = !req_write_b;
      b_nfr   = req_write_b ? 1 : 2;
      b_w0    = {(req_write_b ? 8'h00 : 8'h01), req_addr_b, (req_write_b ? req_wdata_b : 16'h0000)};
    end
  end

  task automatic req_start(input logic w, input logic [7:0] a, input logic [15:0] d, output int h);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    h = cyc;
  endtask

  task automatic req_drop();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(input string nm, output int rc);
    rc = -1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    check({nm, "_rsp_seen"}, 32'(rc >= 0), 1);
  endtask

  task automatic check_frame(input string nm, input int idx, input logic [31:0] w);
    check({nm, "_present"}, 32'(frq.size() > idx), 1);
    if (frq.size() > idx) begin
      check({nm, "_word"}, frq[idx].word, w);
      check({nm, "_rises"}, frq[idx].rises, 32);
      check({nm, "_cs_low"}, frq[idx].low, 256);
    end
  endtask

  logic [7:0] addrs [5] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20};

  initial begin
    int h, rc, rc1, hb, rcb;
    logic op;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) regmem[i] = $urandom;
    regmem[8'h08] = 32'h0000_0005;
    regmem[8'h18] = 32'hDEAD_BEEF;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_pins", {spi_cs_n, spi_sclk, spi_mosi, req_ready, busy, rsp_valid}, 6'b100100);
    check("reset_data", rsp_data, 32'h0);

    // CLK_DIV=2, CS_GAP=1 read of 0x00
    @(posedge clk); #1;
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 8'h00; req_wdata_b = 16'h1234;
    hb = cyc;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    rcb = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rsp_valid_b === 1'b1) begin
        rcb = cyc;
        break;
      end
    end
    check("div2_latency", rcb - hb, 259);
    check("div2_data", rsp_data_b, 32'h5A3C_96E1);

    // write 0x20 <- 0x1458
    frq.delete();
    req_start(1'b1, 8'h20, 16'h1458, h);
    req_drop();
    wait_rsp("wr", rc);
    check("wr_latency", rc - h, 259);
    check_frame("wr_f0", 0, 32'h0020_1458);
    check("wr_rsp_data", rsp_data, 32'h0);

    // read 0x08, responder returns 5 in the dummy frame
    frq.delete();
    req_start(1'b0, 8'h08, 16'hBEEF, h);
    req_drop();
    wait_rsp("rd", rc);
    check("rd_latency", rc - h, 517);
    check_frame("rd_f0", 0, 32'h0108_0000);
    check_frame("rd_f1", 1, 32'hFF00_0000);
    if (frq.size() > 1) check("rd_cs_gap", frq[1].gap, 2);
    check("rd_data", rsp_data, 32'h0000_0005);

    // back-to-back: write 0x10 <- 0x00AB then read 0x18 with req_valid held
    req_start(1'b1, 8'h10, 16'h00AB, h);
    @(posedge clk); #1;
    req_write = 1'b0; req_addr = 8'h18; req_wdata = 16'($urandom);
    wait_rsp("b2b_wr", rc1);
    check("b2b_wr_latency", rc1 - h, 259);
    req_drop();
    wait_rsp("b2b_rd", rc);
    check("b2b_rd_latency", rc - rc1, 517);
    check("b2b_rd_data", rsp_data, 32'hDEAD_BEEF);

    // reset during bit 12 of a read command frame while SCLK is high
    req_start(1'b0, 8'h08, 16'h0, h);
    req_drop();
    repeat (101) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async_pins", {spi_cs_n, spi_sclk}, 2'b10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    frq.delete();
    req_start(1'b1, 8'h00, 16'h0003, h);
    req_drop();
    wait_rsp("post_rst_wr", rc);
    check("post_rst_latency", rc - h, 259);
    check_frame("post_rst_f0", 0, 32'h0000_0003);

    // randomized requests with idle gaps
    for (int k = 0; k < 12; k++) begin
      op = 1'($urandom_range(0, 1));
      a  = addrs[$urandom_range(0, 4)];
      repeat ($urandom_range(0, 4)) @(posedge clk);
      req_start(op, a, 16'($urandom), h);
      req_drop();
      wait_rsp("rand", rc);
      check("rand_latency", rc - h, op ? 259 : 517);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
